// File: rtl/char_tx_sequencer.sv
// rtl/char_tx_sequencer.sv - maps an ASCII character to a display code and sends it as an 8N1 serial frame
// Optional feature macro CHAR_TX_PARITY_EN: adds an even-parity bit between the data bits and the stop bit.
module char_tx_sequencer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] char_in,
    input  logic       char_valid,
    output logic       char_ready,
    output logic       tx_out,
    output logic       busy,
    output logic [7:0] code_out,
    output logic       frame_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef CHAR_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t          r_state;
    logic [CW-1:0]   r_baud;
    logic [2:0]      r_bit;
    logic [7:0]      r_code;
    logic            r_tx;
    logic            r_busy;
    logic            r_ready;
    logic            r_done;

    logic [7:0]      w_map;
    logic            w_accept;
    logic            w_baud_end;
    logic [2:0]      w_next_bit;

    // Quote, percent and backslash are not displayable on the target, so they become spaces.
    always_comb begin
        w_map = 8'h20;
        if (char_in == 8'h0A)
            w_map = 8'h0D;
        else if (char_in >= 8'h20 && char_in <= 8'h7E &&
                 char_in != 8'h22 && char_in != 8'h25 && char_in != 8'h5C)
            w_map = char_in;
    end

    assign w_accept   = char_valid & r_ready;
    assign w_baud_end = (r_baud == BAUD_LAST);
    assign w_next_bit = r_bit + 3'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_code  <= 8'h00;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_baud <= '0;
                    r_bit  <= '0;
                    if (w_accept) begin
                        r_code  <= w_map;
                        r_state <= S_START;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_ready <= 1'b0;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_state <= S_DATA;
                        r_tx    <= r_code[0];
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            r_bit <= '0;
`ifdef CHAR_TX_PARITY_EN
                            r_state <= S_PARITY;
                            r_tx    <= ^r_code;
`else
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
`endif
                        end else begin
                            r_bit <= w_next_bit;
                            r_tx  <= r_code[w_next_bit];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
`ifdef CHAR_TX_PARITY_EN
                S_PARITY: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_state <= S_STOP;
                        r_tx    <= 1'b1;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    // Returning to IDLE with ready set guarantees the one-cycle idle gap before the next start bit.
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                        r_done  <= 1'b1;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_baud  <= '0;
                    r_bit   <= '0;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign char_ready = r_ready;
    assign tx_out     = r_tx;
    assign busy       = r_busy;
    assign code_out   = r_code;
    assign frame_done = r_done;

endmodule

// File: doc/char_tx_sequencer.md
CHAR_TX_SEQUENCER -- requirements
Module: char_tx_sequencer

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 16, clock cycles per serial bit period (legal range 2..65535).
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 char_in  input  8  ASCII character to transmit.
REQ-005 char_valid  input  1  char_in holds a character.
REQ-006 char_ready  output  1  sequencer can accept a character.
REQ-007 tx_out  output  1  serial line; idle high.
REQ-008 busy  output  1  frame in progress.
REQ-009 code_out  output  8  mapped code of the current or last frame.
REQ-010 frame_done  output  1  one-cycle pulse at frame end.

Function
REQ-011 Accept = char_valid & char_ready, sampled on a rising edge; char_ready SHALL be 1 only in IDLE.
REQ-012 Mapping on accept: 0x20-0x7E pass through unchanged, except 0x22, 0x25 and 0x5C, which map to 0x20; 0x0A maps to 0x0D; every other value maps to 0x20.
REQ-013 The mapped code SHALL be registered into code_out on the accept edge and held until the next accept.
REQ-014 FSM states: IDLE, START, DATA, PARITY (only with PARITY_EN), STOP.
REQ-015 IDLE -> START on accept; tx_out=0 from the cycle after accept.
REQ-016 Each of START, DATA bit, PARITY and STOP SHALL last exactly CLKS_PER_BIT cycles, timed by a baud counter that runs 0..CLKS_PER_BIT-1 and restarts at every bit boundary.
REQ-017 DATA SHALL send code_out[0] first through code_out[7], tracked by a 3-bit counter; after bit 7, go to PARITY if compiled in, else to STOP.
REQ-018 STOP drives tx_out=1; after its last cycle the FSM SHALL return to IDLE, and frame_done SHALL be 1 for exactly that transition cycle.
REQ-019 busy=1 in all states except IDLE.
REQ-020 char_valid while busy is ignored; char_in is not sampled and no character is queued.
REQ-021 Minimum gap between frames is one IDLE cycle (tx_out=1).
REQ-022 Frame length is 10 bit periods, or 11 with PARITY_EN.

Reset
REQ-023 While rst=1: state=IDLE, tx_out=1, busy=0, char_ready=0, frame_done=0, code_out=0x00, and all counters=0.
REQ-024 char_ready=1 from the first cycle after rst deasserts.
REQ-025 rst asserted mid-frame SHALL abort the frame: tx_out=1 from the next edge, no frame_done pulse, and the frame is not resumed.

Configuration
REQ-026 Macro CHAR_TX_PARITY_EN defined: the PARITY state is compiled in and sends the even parity of code_out (XOR of its 8 bits) for one bit period between DATA and STOP.
REQ-027 Macro CHAR_TX_PARITY_EN undefined: no PARITY state or parity logic exists, and DATA goes directly to STOP.

Verification
REQ-028 CLKS_PER_BIT=4, send 'A' (0x41) -> tx_out 0,1,0,0,0,0,0,1,0,1, each bit 4 cycles; code_out=0x41; frame_done pulses once after 40 cycles.
REQ-029 Send 0x0A -> code_out=0x0D; data bits 1,0,1,1,0,0,0,0.
REQ-030 Send '%' (0x25), then 0x80 -> code_out=0x20 in both frames.
REQ-031 With CHAR_TX_PARITY_EN, send 'C' (0x43) -> parity bit 1, frame is 44 cycles at CLKS_PER_BIT=4.
REQ-032 Hold char_valid=1 with 'B' then 'Z' changed mid-frame -> only 'B' is sent; 'Z' is accepted in the next IDLE cycle.
REQ-033 Assert rst in the DATA bit-3 period -> next edge gives tx_out=1, busy=0, no frame_done; char_ready=1 one cycle after rst deasserts.
